aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl.sv | 101 ++++++++++
 tb/tb_aes_round_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: walks load, key fetch, AddRoundKey, SubBytes and
// MixColumns for NR rounds, with abort and key-stall handling.
module aes_round_ctrl #(
   parameter int NR = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       key_valid,
   output logic       key_req,
   output logic [3:0] round_num,
   output logic       ld_state,
   output logic       sub_en,
   output logic       mix_en,
   output logic       mix_bypass,
   output logic       ark_en,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_KEY,
      S_ARK,
      S_SUB,
      S_MIX,
      S_DONE
   } state_t;

   localparam logic [3:0] LP_NR = 4'(NR);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_round;
   logic       w_last;

   assign w_last = (r_round == LP_NR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_round <= 4'd0;
      end else begin
         r_state <= w_next;
         if (w_next == S_IDLE || w_next == S_LOAD)
            r_round <= 4'd0;
         else if (r_state == S_ARK && w_next == S_SUB)
            r_round <= r_round + 4'd1;
      end
   end

   // abort overrides every transition, including the IDLE start check
   always_comb begin
      w_next = r_state;
      if (abort) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (start) w_next = S_LOAD;
            S_LOAD: w_next = S_KEY;
            S_KEY:  if (key_valid) w_next = S_ARK;
            S_ARK:  w_next = w_last ? S_DONE : S_SUB;
            S_SUB:  w_next = w_last ? S_KEY : S_MIX;
            S_MIX:  w_next = S_KEY;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      key_req    = 1'b0;
      ld_state   = 1'b0;
      sub_en     = 1'b0;
      mix_en     = 1'b0;
      mix_bypass = 1'b0;
      ark_en     = 1'b0;
      done       = 1'b0;
      busy       = (r_state != S_IDLE);
      case (r_state)
         S_LOAD: ld_state = 1'b1;
         S_KEY: begin
            key_req    = 1'b1;
            mix_bypass = w_last;
         end
         S_ARK: begin
            ark_en     = 1'b1;
            mix_bypass = w_last;
         end
         S_SUB:  sub_en = 1'b1;
         S_MIX:  mix_en = 1'b1;
         S_DONE: done   = 1'b1;
         default: ;
      endcase
   end

   assign round_num = r_round;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl (NR=10 and NR=14 instances)
// against a round-schedule trace model.
module tb_aes_round_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start, abort, key_valid;
   logic       start14, abort14, kv14;
   logic       key_req, ld_state, sub_en, mix_en;
   logic       mix_bypass, ark_en, busy, done;
   logic [3:0] round_num;
   logic       key_req14, ld_state14, sub_en14, mix_en14;
   logic       mix_bypass14, ark_en14, busy14, done14;
   logic [3:0] round_num14;

   aes_round_ctrl #(.NR(10)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .key_valid(key_valid), .key_req(key_req),
      .round_num(round_num), .ld_state(ld_state),
      .sub_en(sub_en), .mix_en(mix_en),
      .mix_bypass(mix_bypass), .ark_en(ark_en),
      .busy(busy), .done(done)
   );

   aes_round_ctrl #(.NR(14)) u_dut14 (
      .clk(clk), .rst(rst), .start(start14), .abort(abort14),
      .key_valid(kv14), .key_req(key_req14),
      .round_num(round_num14), .ld_state(ld_state14),
      .sub_en(sub_en14), .mix_en(mix_en14),
      .mix_bypass(mix_bypass14), .ark_en(ark_en14),
      .busy(busy14), .done(done14)
   );

   // {key_req, round[3:0], ld, sub, mix, bypass, ark, busy, done}
   logic [11:0] o10, o14;
   assign o10 = {key_req, round_num, ld_state, sub_en, mix_en,
                 mix_bypass, ark_en, busy, done};
   assign o14 = {key_req14, round_num14, ld_state14, sub_en14, mix_en14,
                 mix_bypass14, ark_en14, busy14, done14};

   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      logic [11:0] o;
      logic        kv;
      bit          kv_fixed;
   } step_t;

   step_t plan[$];
   int    stall[0:15];

   function automatic logic [11:0] mk(bit kr, int rnd, bit ld, bit sb,
                                      bit mx, bit byp, bit ark, bit bsy,
                                      bit dn);
      return {kr, 4'(rnd), ld, sb, mx, byp, ark, bsy, dn};
   endfunction

   function automatic void push(logic [11:0] o, logic kv, bit fx);
      step_t s;
      s.o = o;
      s.kv = kv;
      s.kv_fixed = fx;
      plan.push_back(s);
   endfunction

   // Expected cycle trace of one block, from the round schedule
   function automatic void build(int nr);
      plan.delete();
      push(mk(0, 0, 1, 0, 0, 0, 0, 1, 0), 1'b0, 1'b0);
      for (int r = 0; r <= nr; r++) begin
         if (r > 0)
            push(mk(0, r, 0, 1, 0, 0, 0, 1, 0), 1'b0, 1'b0);
         if (r > 0 && r < nr)
            push(mk(0, r, 0, 0, 1, 0, 0, 1, 0), 1'b0, 1'b0);
         for (int s = 0; s <= stall[r]; s++)
            push(mk(1, r, 0, 0, 0, r == nr, 0, 1, 0),
                 logic'(s == stall[r]), 1'b1);
         push(mk(0, r, 0, 0, 0, r == nr, 1, 1, 0), 1'b0, 1'b0);
      end
      push(mk(0, nr, 0, 0, 0, 0, 0, 1, 1), 1'b0, 1'b0);
   endfunction

   task automatic drive(input int sel, input logic s, input logic k,
                        input logic a);
      if (sel == 0) begin
         start = s; key_valid = k; abort = a;
      end else begin
         start14 = s; kv14 = k; abort14 = a;
      end
   endtask

   function automatic logic [11:0] obs(input int sel);
      return (sel == 0) ? o10 : o14;
   endfunction

   function automatic void clear_stalls();
      for (int i = 0; i < 16; i++) stall[i] = 0;
   endfunction

   // Entered #1 after an edge in an IDLE cycle; leaves #1 after an edge.
   // stop_kind 1: stop at MIX of stop_round; 2: first cycle of stop_round.
   task automatic run_block(input int sel, input int nr, input bit b2b,
                            input int stop_kind, input int stop_round,
                            input bit do_abort, output int done_at,
                            output int mix_cnt);
      logic [11:0] got, e;
      logic        kv, st;
      bit          hit;
      build(nr);
      done_at = -1;
      mix_cnt = 0;
      drive(sel, 1'b1, 1'($urandom), 1'b0);
      @(negedge clk);
      got = obs(sel);
      n_checks++;
      if (got !== 12'h000) begin
         n_fail++;
         $display("FAIL idle_before_start: got %h expected 000", got);
      end
      @(posedge clk); #1;
      for (int i = 0; i < plan.size(); i++) begin
         kv = plan[i].kv_fixed ? plan[i].kv : 1'($urandom);
         st = b2b ? 1'b1 : 1'($urandom);
         e = plan[i].o;
         hit = (stop_kind == 1 && e[4] && int'(e[10:7]) == stop_round) ||
               (stop_kind == 2 && int'(e[10:7]) == stop_round);
         drive(sel, st, kv, hit && do_abort);
         @(negedge clk);
         got = obs(sel);
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL trace nr=%0d cyc %0d: got %h expected %h",
                     nr, i + 1, got, e);
         end
         if (got[0] && done_at < 0) done_at = i + 1;
         if (got[4]) mix_cnt++;
         if (hit) begin
            if (do_abort) begin
               @(posedge clk); #1;
               drive(sel, 1'b0, 1'b0, 1'b0);
            end
            return;
         end
         @(posedge clk); #1;
      end
      if (!b2b) drive(sel, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0, 1'b0);
      #2;
      n_checks++;
      if (o10 !== 12'h000 || o14 !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h/%h expected 000", o10, o14);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (o10 !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_release_idle: got %h expected 000", o10);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_nominal();
      int d, m;
      clear_stalls();
      run_block(0, 10, 1'b0, 0, 0, 1'b0, d, m);
      n_checks++;
      if (d !== 43 || m !== 9) begin
         n_fail++;
         $display("FAIL nominal_latency: got done %0d mix %0d expected 43 9",
                  d, m);
      end
   endtask

   task automatic test_stall();
      int d, m;
      clear_stalls();
      stall[4] = 5;
      run_block(0, 10, 1'b0, 0, 0, 1'b0, d, m);
      n_checks++;
      if (d !== 48) begin
         n_fail++;
         $display("FAIL stall_latency: got %0d expected 48", d);
      end
   endtask

   task automatic test_random();
      int d, m, sum;
      for (int k = 0; k < 5; k++) begin
         clear_stalls();
         sum = 0;
         for (int r = 0; r <= 10; r++) begin
            stall[r] = $urandom_range(0, 3);
            sum += stall[r];
         end
         run_block(0, 10, 1'b0, 0, 0, 1'b0, d, m);
         n_checks++;
         if (d !== 43 + sum || m !== 9) begin
            n_fail++;
            $display("FAIL random_latency: got %0d/%0d expected %0d/9",
                     d, m, 43 + sum);
         end
      end
   endtask

   task automatic test_abort();
      int d, m;
      clear_stalls();
      run_block(0, 10, 1'b0, 1, 6, 1'b1, d, m);
      n_checks++;
      if (o10 !== 12'h000) begin
         n_fail++;
         $display("FAIL abort_idle: got %h expected 000", o10);
      end
      run_block(0, 10, 1'b0, 0, 0, 1'b0, d, m);
      n_checks++;
      if (d !== 43) begin
         n_fail++;
         $display("FAIL abort_rerun: got %0d expected 43", d);
      end
   endtask

   task automatic test_idle_abort();
      drive(0, 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      n_checks++;
      if (o10 !== 12'h000) begin
         n_fail++;
         $display("FAIL idle_abort_start: got %h expected 000", o10);
      end
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midrun();
      int d, m;
      clear_stalls();
      run_block(0, 10, 1'b0, 2, 3, 1'b0, d, m);
      #2;
      rst = 1'b1;
      drive(0, 1'b1, 1'b1, 1'b0);
      #1;
      n_checks++;
      if (o10 !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_midrun_async: got %h expected 000", o10);
      end
      @(negedge clk);
      n_checks++;
      if (o10 !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_midrun_held: got %h expected 000", o10);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      run_block(0, 10, 1'b0, 0, 0, 1'b0, d, m);
      n_checks++;
      if (d !== 43) begin
         n_fail++;
         $display("FAIL reset_rerun: got %0d expected 43", d);
      end
   endtask

   task automatic test_back_to_back();
      int d, m;
      clear_stalls();
      for (int k = 0; k < 3; k++) begin
         run_block(0, 10, 1'b1, 0, 0, 1'b0, d, m);
         n_checks++;
         if (d !== 43) begin
            n_fail++;
            $display("FAIL b2b_latency run %0d: got %0d expected 43", k, d);
         end
      end
      drive(0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++;
      if (o10 !== 12'h000) begin
         n_fail++;
         $display("FAIL b2b_final_idle: got %h expected 000", o10);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_nr14();
      int d, m;
      clear_stalls();
      run_block(1, 14, 1'b0, 0, 0, 1'b0, d, m);
      n_checks++;
      if (d !== 59 || m !== 13) begin
         n_fail++;
         $display("FAIL nr14_latency: got done %0d mix %0d expected 59 13",
                  d, m);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_stall();
      test_random();
      test_abort();
      test_idle_abort();
      test_reset_midrun();
      test_back_to_back();
      test_nr14();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
